// File: rtl/mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Only the state register is sequential; every control output is decoded from it.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_NOP = 3'b111;

  state_e state_q, state_d;
  logic   pc_write;
  logic   branch;

  // Next-state and control decode
  always_comb begin
    state_d    = S_FETCH;
    alu_sel    = ALU_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_sel   = ALU_ADD;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded
        alu_src_b = 2'b11;
        alu_sel   = ALU_ADD;
        case (opcode)
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h00:        state_d = S_EXEC;
          6'h04:        state_d = S_BEQ;
          6'h08:        state_d = S_ADDIEX;
          6'h02:        state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = ALU_ADD;
        state_d   = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_ALUWB;
        case (funct)
          6'h20:   alu_sel = ALU_ADD;
          6'h22:   alu_sel = ALU_SUB;
          6'h24:   alu_sel = ALU_AND;
          6'h25:   alu_sel = ALU_OR;
          6'h2A:   alu_sel = ALU_SLT;
          6'h18:   alu_sel = ALU_MUL;
          default: begin
            alu_sel = ALU_NOP;
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    pc_en = pc_write | (branch & zero);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: an instruction-level reference model expands each
// instruction into its expected per-cycle control words, checked on the falling edge.
module tb_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       iord;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic [1:0] pcs;
    logic       pce;
    logic       ill;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_en, illegal;
  logic [3:0] state;

  int    checks = 0;
  int    failures = 0;
  ctrl_t obs;
  ctrl_t exp_q[$];

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src), .pc_en(pc_en),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, alu_sel, alu_src_a, alu_src_b, iord, ir_write, mem_write,
                reg_write, reg_dst, mem_to_reg, pc_src, pc_en, illegal};

  function automatic ctrl_t blank(input logic [3:0] st);
    ctrl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic bit op_legal(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
           (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
  endfunction

  // ALU select for an R-type funct; 3'b111 marks an unsupported funct
  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b100;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b110;
      6'h18:   return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  // Expand one instruction into the control word expected in each of its cycles
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    exp_q.delete();
    c = blank(4'd1); c.alu = 3'b010; c.sb = 2'b01; c.irw = 1'b1; c.pce = 1'b1;
    exp_q.push_back(c);
    c = blank(4'd2); c.alu = 3'b010; c.sb = 2'b11; c.ill = !op_legal(op);
    exp_q.push_back(c);
    if (op == 6'h23 || op == 6'h2B) begin
      c = blank(4'd3); c.sa = 1'b1; c.sb = 2'b10; c.alu = 3'b010;
      exp_q.push_back(c);
      if (op == 6'h23) begin
        c = blank(4'd4); c.iord = 1'b1; exp_q.push_back(c);
        c = blank(4'd5); c.m2r = 1'b1; c.rw = 1'b1; exp_q.push_back(c);
      end else begin
        c = blank(4'd6); c.iord = 1'b1; c.mw = 1'b1; exp_q.push_back(c);
      end
    end else if (op == 6'h00) begin
      c = blank(4'd7); c.sa = 1'b1; c.alu = funct_alu(fn); c.ill = (c.alu == 3'b111);
      exp_q.push_back(c);
      if (!c.ill) begin
        c = blank(4'd8); c.rd = 1'b1; c.rw = 1'b1; exp_q.push_back(c);
      end
    end else if (op == 6'h04) begin
      c = blank(4'd9); c.sa = 1'b1; c.alu = 3'b100; c.pcs = 2'b01;
      exp_q.push_back(c);
    end else if (op == 6'h08) begin
      c = blank(4'd10); c.sa = 1'b1; c.sb = 2'b10; c.alu = 3'b010; exp_q.push_back(c);
      c = blank(4'd11); c.rw = 1'b1; exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = blank(4'd12); c.pcs = 2'b10; c.pce = 1'b1; exp_q.push_back(c);
    end
  endtask

  task automatic check(input string tag, input ctrl_t e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (state obs=%0d exp=%0d)", tag, obs, e, obs.st, e.st);
    end
  endtask

  // Run one instruction starting at the falling edge where FETCH is expected.
  // abort_wb pulls reset during MEMWB and returns once FETCH is reached again.
  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input bit abort_wb);
    ctrl_t e;
    build(op, fn);
    foreach (exp_q[i]) begin
      e = exp_q[i];
      if (e.st == 4'd2 || e.st == 4'd3 || e.st == 4'd7) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      zero = 1'($urandom);
      #1;
      if (e.st == 4'd9) e.pce = zero;
      check(tag, e);
      if (abort_wb && e.st == 4'd5) begin
        #1 rst_n = 1'b0;
        #1 check({tag, "_async_rst"}, blank(4'd0));
        @(negedge clk);
        #1 check({tag, "_rst_hold"}, blank(4'd0));
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  logic [5:0] rop, rfn;
  int         kind;
  int         cyc;

  initial begin
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    zero = 1'b1;
    #1 check("reset_state", blank(4'd0));
    rst_n = 1'b1;
    @(negedge clk);

    do_instr("r_add", 6'h00, 6'h20, 1'b0);
    do_instr("lw", 6'h23, 6'h00, 1'b0);
    do_instr("sw", 6'h2B, 6'h00, 1'b0);
    do_instr("beq_a", 6'h04, 6'h00, 1'b0);
    do_instr("beq_b", 6'h04, 6'h00, 1'b0);
    do_instr("ill_op", 6'h3F, 6'h00, 1'b0);
    do_instr("ill_funct", 6'h00, 6'h3F, 1'b0);
    do_instr("addi", 6'h08, 6'h15, 1'b0);
    do_instr("jump", 6'h02, 6'h2A, 1'b0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      rfn  = 6'($urandom);
      case (kind)
        0: rop = 6'h23;
        1: rop = 6'h2B;
        2: begin
          rop = 6'h00;
          case ($urandom_range(0, 5))
            0: rfn = 6'h20;
            1: rfn = 6'h22;
            2: rfn = 6'h24;
            3: rfn = 6'h25;
            4: rfn = 6'h2A;
            default: rfn = 6'h18;
          endcase
        end
        3: begin
          rop = 6'h00;
          while (funct_alu(rfn) != 3'b111) rfn = 6'($urandom);
        end
        4: rop = 6'h04;
        5: rop = 6'h08;
        6: rop = 6'h02;
        default: begin
          rop = 6'($urandom);
          while (op_legal(rop)) rop = 6'($urandom);
        end
      endcase
      do_instr("rand", rop, rfn, 1'b0);
    end

    do_instr("lw_abort", 6'h23, 6'h00, 1'b1);
    do_instr("after_abort", 6'h00, 6'h25, 1'b0);

    // Reset from an arbitrary point must return to IDLE within a bounded window
    cyc = 0;
    rst_n = 1'b0;
    while (state !== 4'd0 && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    #1 check("final_reset", blank(4'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback. It is the driving end of the ALU interface. It produces the 3-bit ALU operation select and the operand-mux controls, and it consumes the ALU zero flag to resolve branches. It also drives the enables for the PC, IR, memory and register file of the shared-memory multicycle datapath.

## Interface
- No parameters; widths fixed by the MIPS ISA.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, same cycle as alu_sel.
- alu_sel  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT, 111 unused (ALU outputs 0).
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load enable.
- mem_write  out  1  memory write enable.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data, 0 = ALUOut.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load = pc_write | (branch & zero), combinational.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- state  out  4  current state encoding, for debug.

## Operation
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BEQ 9, ADDIEX 10, ADDIWB 11, JUMP 12. Codes 13–15 go to FETCH on the next edge with all outputs 0.
- Internal signals pc_write and branch are decoded from state only.
- Outputs are a pure decode of state. Exceptions: alu_sel in EXEC decodes funct; pc_en uses zero; illegal in DECODE and EXEC decodes opcode/funct.
- Any output not listed for a state is 0 in that state.
- IDLE: all outputs 0. Next state FETCH.
- FETCH: iord=0, src_a=0, src_b=01, ADD, pc_src=00, ir_write=1, pc_write=1. Next DECODE.
- DECODE: src_a=0, src_b=11, ADD (precomputes branch target).
  - Next state by opcode: 0x23 or 0x2B → MEMADR; 0x00 → EXEC; 0x04 → BEQ; 0x08 → ADDIEX; 0x02 → JUMP.
  - Any other opcode: illegal=1, next FETCH.
- MEMADR: src_a=1, src_b=10, ADD. Next MEMRD if opcode=0x23, else MEMWR.
- MEMRD: iord=1. Next MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWR: iord=1, mem_write=1. Next FETCH.
- EXEC: src_a=1, src_b=00.
  - funct 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x25 → OR, 0x2A → SLT, 0x18 → MUL; next ALUWB.
  - Any other funct: alu_sel=111, illegal=1, next FETCH (no writeback).
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
- BEQ: src_a=1, src_b=00, SUB, pc_src=01, branch=1. Next FETCH.
- ADDIEX: src_a=1, src_b=10, ADD. Next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- JUMP: pc_src=10, pc_write=1. Next FETCH.

## Timing
- Only the state register is sequential; it updates on the rising edge of clk.
- Reset (rst_n low) forces IDLE immediately, without waiting for a clock edge. All outputs read 0: alu_sel=000, pc_src=00, alu_src_b=00, state=0, pc_en=0, illegal=0.
- The first edge after rst_n rises moves IDLE to FETCH.
- Instruction latency, FETCH to next FETCH:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
  - Illegal funct: 3 cycles.
- pc_en follows zero combinationally during BEQ. Outside BEQ and FETCH/JUMP it is 0 regardless of zero.
- Reset asserted mid-instruction aborts the instruction: write enables drop in the same cycle and no partial writeback occurs.
- opcode and funct are sampled only in DECODE, MEMADR and EXEC; changes in other states have no effect.

## Test plan
- Reset and release: rst_n low for 3 cycles → state=0, all outputs 0. First edge after release → state=1, ir_write=1, pc_en=1, alu_sel=010, alu_src_b=01.
- R-type add: opcode=0x00, funct=0x20 → states 1,2,7,8,1. alu_sel=010 in EXEC. reg_write=1 and reg_dst=1 in ALUWB only.
- lw then sw: opcode 0x23 → 1,2,3,4,5, with mem_to_reg=1 and reg_write=1 in MEMWB. Opcode 0x2B → 1,2,3,6, with mem_write=1 and iord=1 in MEMWR only.
- beq: opcode 0x04. With zero=1 in BEQ → pc_en=1, pc_src=01, alu_sel=100. With zero=0 → pc_en=0. Both return to FETCH after 3 cycles.
- Illegal cases: opcode 0x3F → illegal=1 in DECODE, then FETCH; no write enable asserted. R-type funct 0x3F → alu_sel=111, illegal=1 in EXEC, no ALUWB.
- Mid-instruction reset: rst_n pulled low during MEMWB → reg_write drops to 0 asynchronously, state=0. After release, execution resumes at FETCH.
